// File: rtl/page_walk_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ptw_pkg
//   Shared types and helpers for the page walk scheduler.
//   - ptw_state_e : walker FSM state (IDLE / SCAN / RESP).
//   - pte_* functions : bit positions of the fields inside a page-table
//     entry laid out as {valid, vpn[VPN_W-1:0], ppn[PPN_W-1:0]}.
//   - PTE_* localparams : the same positions for the default 5/5 widths.
// ---------------------------------------------------------------------------
package ptw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } ptw_state_e;

  localparam int DEF_VPN_W = 5;
  localparam int DEF_PPN_W = 5;

  // Entry layout helpers, usable with any VPN/PPN width.
  function automatic int pte_valid_bit(input int vpn_w, input int ppn_w);
    return vpn_w + ppn_w;
  endfunction

  function automatic int pte_vpn_msb(input int vpn_w, input int ppn_w);
    return vpn_w + ppn_w - 1;
  endfunction

  function automatic int pte_vpn_lsb(input int ppn_w);
    return ppn_w;
  endfunction

  function automatic int pte_ppn_msb(input int ppn_w);
    return ppn_w - 1;
  endfunction

  localparam int PTE_VALID_BIT = pte_valid_bit(DEF_VPN_W, DEF_PPN_W);
  localparam int PTE_VPN_MSB   = pte_vpn_msb(DEF_VPN_W, DEF_PPN_W);
  localparam int PTE_VPN_LSB   = pte_vpn_lsb(DEF_PPN_W);
  localparam int PTE_PPN_MSB   = pte_ppn_msb(DEF_PPN_W);
  localparam int PTE_PPN_LSB   = 0;

endpackage

// File: rtl/page_walk_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Grants the first asserted request
//   found when searching upward from ptr, wrapping past N_REQ-1 to 0.
//   Ports:
//     req   [N_REQ-1:0] : request vector
//     ptr   [PTR_W-1:0] : index with highest priority this cycle
//     grant [N_REQ-1:0] : one-hot grant (all zero when req is zero)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic found;

  // Two passes avoid a modulo index: first [ptr, N_REQ-1], then [0, ptr-1].
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && (i >= int'(ptr)) && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && (i < int'(ptr)) && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/page_walk_scheduler.sv
// ---------------------------------------------------------------------------
// page_walk_scheduler
//   Shares one page-table read port between N_REQ TLB-miss clients. One
//   request is accepted at a time (round robin), the table is scanned
//   linearly one entry per cycle against a 1-cycle-latency read port, and a
//   single-cycle response goes back to the accepted client.
//
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     req_valid    : per-client request
//     req_vpn      : client i VPN at [i*VPN_W +: VPN_W]
//     req_ready    : one-hot accept (IDLE only)
//     resp_valid   : one-hot, one-cycle response pulse
//     resp_hit     : translation found (held until next response)
//     resp_ppn     : translated PPN, 0 on miss (held until next response)
//     pt_rd_en     : page-table read strobe
//     pt_rd_idx    : page-table read index
//     pt_rd_data   : {valid, vpn, ppn}, returned the cycle after pt_rd_en
//     busy         : FSM not in IDLE
//     dbg_state    : current FSM state
//
//   Handshake: a request transfers on a rising edge where
//   req_valid[i] & req_ready[i] are both high. req_ready is combinational,
//   one-hot, only in IDLE and never during reset; a client must hold
//   req_valid/req_vpn stable until accepted and may withdraw at any time.
//   resp_valid carries no back-pressure: it is a one-cycle pulse.
// ---------------------------------------------------------------------------
module page_walk_scheduler
  import ptw_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int VPN_W      = 5,
  parameter int PPN_W      = 5,
  parameter int PT_ENTRIES = 32,
  // 2**IDX_W must be >= PT_ENTRIES.
  parameter int IDX_W      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*VPN_W-1:0]   req_vpn,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         resp_valid,
  output logic                     resp_hit,
  output logic [PPN_W-1:0]         resp_ppn,
  output logic                     pt_rd_en,
  output logic [IDX_W-1:0]         pt_rd_idx,
  input  logic [1+VPN_W+PPN_W-1:0] pt_rd_data,
  output logic                     busy,
  output ptw_state_e               dbg_state
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int VLD_BIT = pte_valid_bit(VPN_W, PPN_W);
  localparam int VPN_MSB = pte_vpn_msb(VPN_W, PPN_W);
  localparam int VPN_LSB = pte_vpn_lsb(PPN_W);
  localparam int PPN_MSB = pte_ppn_msb(PPN_W);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PT_ENTRIES - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(N_REQ - 1);

  // Registered state
  ptw_state_e       state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] client_q;
  logic [VPN_W-1:0] vpn_q;
  logic             rd_en_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             data_vld_q;   // pt_rd_data carries a real entry this cycle
  logic [IDX_W-1:0] cmp_idx_q;    // index of the entry on pt_rd_data
  logic [N_REQ-1:0] resp_valid_q;
  logic             hit_q;
  logic [PPN_W-1:0] ppn_q;

  // Combinational
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] ptr_d;
  logic [VPN_W-1:0] req_vpn_sel;
  logic [N_REQ-1:0] client_oh;
  logic             accept;
  logic             match;
  logic             last_cmp;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Ready is only offered from IDLE, and withheld while reset is applied.
  assign req_ready = ((state_q == IDLE) && !rst) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    winner      = '0;
    req_vpn_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        winner      = PTR_W'(i);
        req_vpn_sel = req_vpn[i*VPN_W +: VPN_W];
      end
    end
  end

  assign ptr_d = (winner == LAST_PTR) ? '0 : winner + 1'b1;

  always_comb begin
    client_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      client_oh[i] = (client_q == PTR_W'(i));
    end
  end

  // data_vld_q gates the compare so an X bus on idle read cycles is ignored.
  assign match    = data_vld_q && pt_rd_data[VLD_BIT] &&
                    (pt_rd_data[VPN_MSB:VPN_LSB] == vpn_q);
  assign last_cmp = data_vld_q && (cmp_idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      client_q     <= '0;
      vpn_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_idx_q     <= '0;
      data_vld_q   <= 1'b0;
      cmp_idx_q    <= '0;
      resp_valid_q <= '0;
      hit_q        <= 1'b0;
      ppn_q        <= '0;
    end else begin
      // Read pipeline bookkeeping: what is issued now is compared next cycle.
      data_vld_q   <= rd_en_q;
      cmp_idx_q    <= rd_idx_q;
      resp_valid_q <= '0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            vpn_q    <= req_vpn_sel;
            client_q <= winner;
            ptr_q    <= ptr_d;
            rd_en_q  <= 1'b1;
            rd_idx_q <= '0;
            state_q  <= SCAN;
          end
        end

        SCAN: begin
          if (match) begin
            // The read issued this cycle is dropped by clearing rd_en_q.
            hit_q        <= 1'b1;
            ppn_q        <= pt_rd_data[PPN_MSB:0];
            rd_en_q      <= 1'b0;
            resp_valid_q <= client_oh;
            state_q      <= RESP;
          end else if (last_cmp) begin
            hit_q        <= 1'b0;
            ppn_q        <= '0;
            rd_en_q      <= 1'b0;
            resp_valid_q <= client_oh;
            state_q      <= RESP;
          end else if (rd_en_q) begin
            // Stop issuing once the last entry is out; the scan then waits
            // one cycle for its compare.
            if (rd_idx_q == LAST_IDX) begin
              rd_en_q <= 1'b0;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = hit_q;
  assign resp_ppn   = ppn_q;
  assign pt_rd_en   = rd_en_q;
  assign pt_rd_idx  = rd_idx_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_page_walk_scheduler.sv
// ---------------------------------------------------------------------------
// tb_page_walk_scheduler
//   Bench for page_walk_scheduler: page-table memory model, request driver,
//   reference model (linear table search + round-robin pick) and a
//   scoreboard queue of accepted requests matched against responses.
// ---------------------------------------------------------------------------
module tb_page_walk_scheduler;
  import ptw_pkg::*;

  localparam int N_REQ      = 2;
  localparam int VPN_W      = 5;
  localparam int PPN_W      = 5;
  localparam int PT_ENTRIES = 32;
  localparam int IDX_W      = 5;
  localparam int ENT_W      = 1 + VPN_W + PPN_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*VPN_W-1:0] req_vpn;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       resp_valid;
  logic                   resp_hit;
  logic [PPN_W-1:0]       resp_ppn;
  logic                   pt_rd_en;
  logic [IDX_W-1:0]       pt_rd_idx;
  logic [ENT_W-1:0]       pt_rd_data;
  logic                   busy;
  ptw_state_e             dbg_state;

  page_walk_scheduler #(
    .N_REQ(N_REQ), .VPN_W(VPN_W), .PPN_W(PPN_W),
    .PT_ENTRIES(PT_ENTRIES), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vpn(req_vpn), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ppn(resp_ppn),
    .pt_rd_en(pt_rd_en), .pt_rd_idx(pt_rd_idx), .pt_rd_data(pt_rd_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- page-table memory model ----------------
  logic [ENT_W-1:0] pt_mem [PT_ENTRIES];
  int               bad_idx = 0;

  // Garbage on the bus when nothing was read stands in for X.
  always @(posedge clk) begin
    if (pt_rd_en) begin
      pt_rd_data <= pt_mem[pt_rd_idx];
      if (int'(pt_rd_idx) >= PT_ENTRIES) bad_idx <= bad_idx + 1;
    end else begin
      pt_rd_data <= ENT_W'($urandom);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int             model_ptr  = 0;
  logic           model_busy = 1'b0;
  logic [31:0]    exp_q[$];   // {t0[15:0], vpn[7:0], client[7:0]}

  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v, input int p);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int c;
      c = (p + k) % N_REQ;
      if (v[c] && r == '0) r[c] = 1'b1;
    end
    return r;
  endfunction

  // Lowest valid entry with equal VPN wins; result appears k+3 cycles after
  // acceptance, a full miss after PT_ENTRIES+2.
  task automatic model_lookup(input logic [VPN_W-1:0] vpn, output logic hit,
                              output logic [PPN_W-1:0] ppn, output int lat);
    hit = 1'b0; ppn = '0; lat = PT_ENTRIES + 2;
    for (int i = PT_ENTRIES - 1; i >= 0; i--) begin
      if (pt_mem[i][ENT_W-1] && pt_mem[i][ENT_W-2 -: VPN_W] == vpn) begin
        hit = 1'b1; ppn = pt_mem[i][PPN_W-1:0]; lat = i + 3;
      end
    end
  endtask

  function automatic logic [ENT_W-1:0] pte(input logic v, input logic [VPN_W-1:0] vpn,
                                           input logic [PPN_W-1:0] ppn);
    return {v, vpn, ppn};
  endfunction

  task automatic clear_table();
    for (int i = 0; i < PT_ENTRIES; i++) pt_mem[i] = pte(1'b0, VPN_W'(i), PPN_W'(i));
  endtask

  task automatic random_table();
    for (int i = 0; i < PT_ENTRIES; i++)
      pt_mem[i] = pte(1'($urandom_range(0, 1)), VPN_W'($urandom_range(0, 7)),
                      PPN_W'($urandom));
  endtask

  // ---------------- driver ----------------
  int               cyc = 0;
  logic [N_REQ-1:0] drv_valid = '0;
  logic [VPN_W-1:0] drv_vpn [N_REQ];
  logic [N_REQ-1:0] acc_last = '0;
  logic             last_hit;
  logic [PPN_W-1:0] last_ppn;
  int               last_lat;

  task automatic apply_inputs();
    req_valid = drv_valid;
    for (int c = 0; c < N_REQ; c++) req_vpn[c*VPN_W +: VPN_W] = drv_vpn[c];
  endtask

  // mode 0: random requests; 1: all clients hold requests; 2: caller's
  // requests only, dropped once accepted.
  task automatic run_traffic(input int mode, input int n_resp, input int max_cyc);
    int               got;
    int               waited;
    logic [N_REQ-1:0] exp_rdy;
    logic [31:0]      e;
    logic             eh;
    logic [PPN_W-1:0] ep;
    int               el;
    int               c;
    logic [N_REQ-1:0] oh;
    got = 0; waited = 0;
    while (got < n_resp && waited < max_cyc) begin
      @(negedge clk);
      cyc++; waited++;
      for (int k = 0; k < N_REQ; k++) begin
        if (acc_last[k] && mode != 1) drv_valid[k] = 1'b0;
        if (mode == 0) begin
          if (!drv_valid[k] && $urandom_range(0, 2) == 0) begin
            drv_valid[k] = 1'b1;
            drv_vpn[k]   = VPN_W'($urandom_range(0, 9));
          end else if (drv_valid[k] && $urandom_range(0, 15) == 0) begin
            drv_valid[k] = 1'b0;
          end
        end
      end
      acc_last = '0;
      apply_inputs();
      #1;
      exp_rdy = model_busy ? '0 : rr_pick(drv_valid, model_ptr);
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(model_busy));
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          c = int'(e[7:0]);
          model_lookup(e[8 +: VPN_W], eh, ep, el);
          oh = '0; oh[c] = 1'b1;
          check("resp_client", 32'(resp_valid), 32'(oh));
          check("resp_hit", 32'(resp_hit), 32'(eh));
          check("resp_ppn", 32'(resp_ppn), 32'(ep));
          check("resp_latency", 32'(cyc - int'(e[31:16])), 32'(el));
          check("rd_after_done", 32'(pt_rd_en), 32'h0);
          last_hit = resp_hit; last_ppn = resp_ppn; last_lat = cyc - int'(e[31:16]);
          model_busy = 1'b0;
          got++;
        end
      end
      if (exp_rdy != '0) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (exp_rdy[k]) begin
            exp_q.push_back({16'(cyc), 8'(drv_vpn[k]), 8'(k)});
            model_ptr = (k + 1) % N_REQ;
          end
        end
        model_busy = 1'b1;
        acc_last   = exp_rdy;
      end
    end
    if (got < n_resp) check("traffic_timeout", 32'(got), 32'(n_resp));
    @(negedge clk);
    drv_valid = '0;
    acc_last  = '0;
    apply_inputs();
  endtask

  task automatic directed(input string tag, input logic [VPN_W-1:0] vpn, input logic eh,
                          input logic [PPN_W-1:0] ep, input int el);
    drv_valid = 2'b01;
    drv_vpn[0] = vpn;
    last_hit = 1'bx; last_ppn = 'x; last_lat = -1;
    run_traffic(2, 1, 100);
    check({tag, "_hit"}, 32'(last_hit), 32'(eh));
    check({tag, "_ppn"}, 32'(last_ppn), 32'(ep));
    check({tag, "_lat"}, 32'(last_lat), 32'(el));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int resp_seen;
    drv_vpn[0] = '0; drv_vpn[1] = '0;
    apply_inputs();
    clear_table();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // Reset state, with requests present to confirm ready is withheld.
    drv_valid = 2'b11;
    apply_inputs();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rd_en", 32'(pt_rd_en), 32'h0);
    check("rst_rd_idx", 32'(pt_rd_idx), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_hit", 32'(resp_hit), 32'h0);
    check("rst_resp_ppn", 32'(resp_ppn), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    drv_valid = '0;
    apply_inputs();
    rst = 1'b0;

    // Hit on entry 0.
    clear_table();
    pt_mem[0] = pte(1'b1, 5'h03, 5'h11);
    directed("hit0", 5'h03, 1'b1, 5'h11, 3);

    // Hit on the last entry.
    clear_table();
    pt_mem[31] = pte(1'b1, 5'h1F, 5'h0A);
    directed("hit31", 5'h1F, 1'b1, 5'h0A, 34);

    // VPN-matching but invalid entry: full miss.
    clear_table();
    pt_mem[7] = pte(1'b0, 5'h08, 5'h04);
    directed("miss", 5'h08, 1'b0, 5'h00, 34);

    // Duplicate mappings: lowest index wins.
    clear_table();
    pt_mem[2] = pte(1'b1, 5'h04, 5'h12);
    pt_mem[9] = pte(1'b1, 5'h04, 5'h19);
    directed("dup", 5'h04, 1'b1, 5'h12, 5);

    // Reset in the middle of a scan.
    clear_table();
    pt_mem[20] = pte(1'b1, 5'h03, 5'h07);
    @(negedge clk);
    drv_valid = 2'b01; drv_vpn[0] = 5'h03;
    apply_inputs();
    #1;
    check("midrst_t0_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    drv_valid = '0;
    apply_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("midrst_t4_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_t5_busy", 32'(busy), 32'h0);
    check("midrst_t5_rd_en", 32'(pt_rd_en), 32'h0);
    rst = 1'b0;
    resp_seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (resp_valid != '0) resp_seen++;
    end
    check("midrst_no_resp", 32'(resp_seen), 32'h0);
    model_ptr = 0; model_busy = 1'b0; exp_q.delete(); acc_last = '0;

    // Round robin with both clients requesting continuously.
    clear_table();
    pt_mem[4] = pte(1'b1, 5'h01, 5'h15);
    pt_mem[1] = pte(1'b1, 5'h02, 5'h0C);
    drv_valid = 2'b11; drv_vpn[0] = 5'h01; drv_vpn[1] = 5'h02;
    run_traffic(1, 4, 200);

    // Random traffic over random tables.
    for (int r = 0; r < 4; r++) begin
      random_table();
      run_traffic(0, 8, 3000);
    end

    check("rd_idx_range", 32'(bad_idx), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
